window_3x3_gen: RTL
===================

// Module: window_3x3_gen
// PURPOSE
//  Builds a 3x3 pixel window stream from a 1 pixel/cycle video stream. It is the producer side of the
//  in3x3_* interface consumed by the laplace/sharpen filters. It holds the previous two lines in line
//  buffers and emits one window per interior pixel. The output frame is (W-2)x(H-2); only full windows
//  are emitted.
// PARAMETERS
//  DATA_WIDTH  8     bits per pixel
//  MAX_WIDTH   1024  max pixels per line (line buffer depth)
//  COL_WIDTH   11    column/row counter width; must satisfy 2**COL_WIDTH > MAX_WIDTH
// PORTS
//  clk          in   1             system clock
//  rst          in   1             synchronous reset, active high
//  in_val       in   1             upstream pixel valid
//  in_rdy       out  1             block can accept a pixel
//  in_data      in   DATA_WIDTH    pixel
//  in_sof       in   1             start of frame (first pixel)
//  in_eof       in   1             end of frame (last pixel)
//  in_sol       in   1             start of line
//  in_eol       in   1             end of line
//  out3x3_val   out  1             window valid
//  out3x3_rdy   in   1             downstream ready
//  out3x3_data  out  9*DATA_WIDTH  window; element k=3*row+col at [(k+1)*DW-1:k*DW], row0=top, col0=left
//  out3x3_sof   out  1             first window of frame
//  out3x3_eof   out  1             last window of frame
//  out3x3_sol   out  1             first window of line
//  out3x3_eol   out  1             last window of line
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - Accept = in_val & in_rdy. in_rdy = ~out3x3_val | out3x3_rdy (single output register stage).
//  - Reset: out3x3_val, out3x3_data and all out3x3 flags = 0; row and col counters = 0.
//    Line buffer contents are not reset.
//  - Counters advance only on accept. col = index in line; row = index in frame.
//    An accept with in_sof forces row=0,col=0 for that pixel (resync, even mid-frame).
//    An accept with in_sol forces col=0. After an accept with in_eol: col<=0, row<=row+1.
//    row saturates at all-ones.
//  - Every accepted pixel with col<MAX_WIDTH shifts into the 3 window columns:
//    bottom row = new pixel, middle = linebuf1[col], top = linebuf0[col].
//    It writes linebuf1[col]<=pixel and linebuf0[col]<=old linebuf1[col].
//    Pixels with col>=MAX_WIDTH are accepted and discarded: no write, no output.
//    col saturates at MAX_WIDTH.
//  - Window emit: accepted pixel with row>=2 and 2<=col<MAX_WIDTH. Center is input pixel (row-1,col-1),
//    at element k=4.
//  - Latency: out3x3_val rises the cycle after the emitting accept. Data and flags are registered
//    at the same time.
//  - Flags on emit: sol = (col==2); eol = in_eol; sof = (row==2 & col==2); eof = in_eof.
//    Flags of non-emitting pixels are lost. An eof on a line with width<3 or frame height<3
//    produces no output.
//  - Hold: while out3x3_val & ~out3x3_rdy, all out3x3_* stay stable and in_rdy=0.
//    out3x3_val clears on out3x3_rdy when no new emit occurs the same cycle.
//    Emit and drain in the same cycle: new window loaded, val stays 1.
//  - Lines shorter than the previous line: stale linebuf entries beyond the current width are never
//    read for emitted windows, because only col<=current col is used.
// TESTING
//  - 5x4 frame, pix=16*r+c, out3x3_rdy=1 -> 6 windows. First window data = {0x22,0x21,0x20,0x12,0x11,
//    0x10,0x02,0x01,0x00} (k8..k0) with sof=sol=1. eol on windows 3 and 6; eof on window 6 only.
//  - Same frame, out3x3_rdy toggling 1/0 randomly -> identical window sequence, in_rdy=0 while
//    stalled, out3x3_data stable during stall.
//  - Frame of width 2, height 5 -> zero output windows, no sof/eof emitted, counters return to 0
//    on next sof.
//  - in_sof asserted at pixel (3,2) of a 5x5 frame -> restarts; next emit only after 2 new full lines.
//    First emitted window has sof=1.
//  - rst asserted mid-line while out3x3_val=1 -> next cycle out3x3_val=0 and flags 0. A fresh 4x4 frame
//    yields exactly 4 correct windows.
//  - Line of MAX_WIDTH+2 pixels with eol on the last -> MAX_WIDTH-2 windows for that row, eol=1 on none.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Turns a 1 pixel/cycle video stream into a stream of 3x3 windows, one per interior pixel.
// Two line buffers hold the previous lines; a single output register stage carries the window and flags.
module window_3x3_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 1024,
    parameter int COL_WIDTH  = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_sof,
    input  logic                    in_eof,
    input  logic                    in_sol,
    input  logic                    in_eol,
    output logic                    out3x3_val,
    input  logic                    out3x3_rdy,
    output logic [9*DATA_WIDTH-1:0] out3x3_data,
    output logic                    out3x3_sof,
    output logic                    out3x3_eof,
    output logic                    out3x3_sol,
    output logic                    out3x3_eol
);

    localparam int ADDR_WIDTH = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int DW         = DATA_WIDTH;
    localparam logic [COL_WIDTH-1:0] MAX_COL = COL_WIDTH'(MAX_WIDTH);
    localparam logic [COL_WIDTH-1:0] TWO     = COL_WIDTH'(2);
    localparam logic [COL_WIDTH-1:0] ONE     = COL_WIDTH'(1);

    logic [DW-1:0] linebuf0 [MAX_WIDTH];
    logic [DW-1:0] linebuf1 [MAX_WIDTH];

    logic [COL_WIDTH-1:0]  row, col;
    logic [COL_WIDTH-1:0]  cur_row, cur_col, nxt_row, nxt_col;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept, in_range, emit;
    logic [DW-1:0]         top_pix, mid_pix;
    logic [9*DW-1:0]       win, win_nxt;

    assign in_rdy = ~out3x3_val | out3x3_rdy;

    always_comb begin
        accept   = in_val & in_rdy;
        // sof/sol take effect on the pixel that carries them, not the next one
        cur_row  = in_sof ? '0 : row;
        cur_col  = (in_sof | in_sol) ? '0 : col;
        in_range = cur_col < MAX_COL;
        emit     = accept & in_range & (cur_row >= TWO) & (cur_col >= TWO);
        addr     = cur_col[ADDR_WIDTH-1:0];
        top_pix  = linebuf0[addr];
        mid_pix  = linebuf1[addr];

        win_nxt = win;
        for (int r = 0; r < 3; r++) begin
            win_nxt[(3*r)*DW +: DW]   = win[(3*r+1)*DW +: DW];
            win_nxt[(3*r+1)*DW +: DW] = win[(3*r+2)*DW +: DW];
        end
        win_nxt[2*DW +: DW] = top_pix;
        win_nxt[5*DW +: DW] = mid_pix;
        win_nxt[8*DW +: DW] = in_data;

        if (in_eol) begin
            nxt_col = '0;
            nxt_row = (&cur_row) ? cur_row : cur_row + ONE;
        end else begin
            nxt_col = in_range ? cur_col + ONE : MAX_COL;
            nxt_row = cur_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            out3x3_val  <= 1'b0;
            out3x3_data <= '0;
            out3x3_sof  <= 1'b0;
            out3x3_eof  <= 1'b0;
            out3x3_sol  <= 1'b0;
            out3x3_eol  <= 1'b0;
        end else begin
            if (accept) begin
                row <= nxt_row;
                col <= nxt_col;
            end
            if (emit) begin
                out3x3_val  <= 1'b1;
                out3x3_data <= win_nxt;
                out3x3_sof  <= (cur_row == TWO) & (cur_col == TWO);
                out3x3_eof  <= in_eof;
                out3x3_sol  <= (cur_col == TWO);
                out3x3_eol  <= in_eol;
            end else if (out3x3_rdy) begin
                out3x3_val <= 1'b0;
            end
        end
    end

    // Line buffers and the window shifter are data path only and carry no reset.
    always_ff @(posedge clk) begin
        if (accept & in_range) begin
            linebuf1[addr] <= in_data;
            linebuf0[addr] <= mid_pix;
            win            <= win_nxt;
        end
    end

endmodule
